lsu_ctrl: RTL and testbench

- Load/store unit control stage. Sits directly upstream of the data-memory wrapper and drives its en/wr/addr/wdata/wstrb request bundle.
- Consumes its rdata and returns aligned, sign/zero-extended load results to writeback.
- Accepts one access at a time from execute via valid/ready and returns one result via valid/ready.
- Owns byte-lane steering, strobe generation, the memory-latency wait and misalignment detection.

---
 rtl/lsu_ctrl_if.sv | 37 +++
 rtl/lsu_ctrl.sv | 157 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl bus bundle: execute request, writeback response and data-memory port.
// slave is the LSU side; master is the surrounding pipeline/memory side.
interface lsu_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_store;
   logic [2:0]  in_op;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic [4:0]  out_rd;
   logic        out_store;
   logic        out_misalign;
   logic        mem_en;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport slave (
      input  in_valid, in_store, in_op, in_addr, in_wdata, in_rd,
      input  out_ready, mem_rdata,
      output in_ready, out_valid, out_rdata, out_rd, out_store,
      output out_misalign, mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output in_valid, in_store, in_op, in_addr, in_wdata, in_rd,
      output out_ready, mem_rdata,
      input  in_ready, out_valid, out_rdata, out_rd, out_store,
      input  out_misalign, mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage: lane steering, strobes, memory wait, extension.
// Optional misalignment trap enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_ctrl #(
   parameter int MEM_LAT = 0
) (
   input  logic      clock,
   input  logic      reset,
   lsu_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [2:0] LAT_M1 =
      (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

   state_t      state, state_nxt;
   logic        store_q;
   logic [2:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [4:0]  rd_q;
   logic        mis_q;
   logic [2:0]  cnt;

   logic        accept;
   logic        mis;
   logic        sample;
   logic        is_b;
   logic        is_h;
   logic [1:0]  ofs;
   logic [4:0]  sh;
   logic [3:0]  strb;
   logic [31:0] shifted;
   logic [31:0] ext;

   logic        in_ready;
   logic        out_valid;
   logic        mem_en;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;

   assign accept = bus.in_valid && (state == IDLE);

`ifdef LSU_MISALIGN_CHK_EN
   assign mis = ((bus.in_op[1:0] == 2'b01) && bus.in_addr[0]) ||
                (bus.in_op[1] && (bus.in_addr[1:0] != 2'b00));
`else
   assign mis = 1'b0;
`endif

   assign is_b = (op_q[1:0] == 2'b00);
   assign is_h = (op_q[1:0] == 2'b01);

   // Offset snaps to the natural size so unchecked odd accesses stay in-word.
   always_comb begin
      ofs  = 2'b00;
      strb = 4'b1111;
      unique case (1'b1)
         is_b: begin
            ofs  = addr_q[1:0];
            strb = 4'b0001 << addr_q[1:0];
         end
         is_h: begin
            ofs  = {addr_q[1], 1'b0};
            strb = 4'b0011 << {addr_q[1], 1'b0};
         end
         default: begin
            ofs  = 2'b00;
            strb = 4'b1111;
         end
      endcase
   end

   assign sh      = {ofs, 3'b000};
   assign shifted = bus.mem_rdata >> sh;

   always_comb begin
      ext = shifted;
      unique case (1'b1)
         is_b: ext = op_q[2] ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
         is_h: ext = op_q[2] ? {16'h0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   assign sample = ((state == REQ) && !store_q && (MEM_LAT == 0)) ||
                   ((state == WAIT) && (cnt == 3'd0));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = mis ? RESP : REQ;
         REQ: begin
            if (store_q || (MEM_LAT == 0)) state_nxt = RESP;
            else                           state_nxt = WAIT;
         end
         WAIT: if (cnt == 3'd0) state_nxt = RESP;
         RESP: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == RESP);
      mem_en    = (state == REQ);
      mem_wr    = (state == REQ) && store_q;
      mem_wstrb = mem_wr ? strb : 4'b0000;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         store_q <= 1'b0;
         op_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rd_q    <= 5'h0;
         mis_q   <= 1'b0;
         rdata_q <= 32'h0;
         cnt     <= 3'd0;
      end else begin
         if (accept) begin
            store_q <= bus.in_store;
            op_q    <= bus.in_op;
            addr_q  <= bus.in_addr;
            wdata_q <= bus.in_wdata;
            rd_q    <= bus.in_rd;
            mis_q   <= mis;
            rdata_q <= 32'h0;
         end
         if (state == REQ)       cnt <= LAT_M1;
         else if (state == WAIT) cnt <= cnt - 3'd1;
         if (sample) rdata_q <= ext;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid;
   assign bus.out_rdata    = rdata_q;
   assign bus.out_rd       = rd_q;
   assign bus.out_store    = store_q;
   assign bus.out_misalign = mis_q;
   assign bus.mem_en       = mem_en;
   assign bus.mem_wr       = mem_wr;
   assign bus.mem_addr     = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata    = wdata_q << sh;
   assign bus.mem_wstrb    = mem_wstrb;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: MEM_LAT=2 main instance, MEM_LAT=5 for reset abort.
// Expected values are hand-computed constants.
module tb_lsu_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;

   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   always #5 clk = ~clk;

   lsu_ctrl_if b ();
   lsu_ctrl_if b5 ();

   lsu_ctrl #(.MEM_LAT(2)) u2 (.clock(clk), .reset(rst_n), .bus(b));
   lsu_ctrl #(.MEM_LAT(5)) u5 (.clock(clk), .reset(rst_n), .bus(b5));

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
      @(negedge clk);
      b.in_valid  = 1'b1;
      b.in_store  = st;
      b.in_op     = op;
      b.in_addr   = a;
      b.in_wdata  = wd;
      b.in_rd     = rd;
      b.mem_rdata = JUNK;
      @(negedge clk);
      b.in_valid  = 1'b0;
   endtask

   task automatic take(input string tag, input logic [31:0] rdata,
                       input logic [4:0] rd, input logic st,
                       input logic mis);
      check({tag, "_data"}, b.out_rdata, rdata);
      check({tag, "_ctl"},
            32'({b.out_valid, b.in_ready, b.out_store, b.out_misalign, b.out_rd}),
            32'({1'b1, 1'b0, st, mis, rd}));
      b.out_ready = 1'b1;
      @(negedge clk);
      b.out_ready = 1'b0;
      check({tag, "_idle"}, 32'({b.out_valid, b.in_ready, b.mem_en}),
            32'({1'b0, 1'b1, 1'b0}));
   endtask

   task automatic store(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [3:0] strb,
                        input logic [31:0] lane, input logic [31:0] waddr);
      send(1'b1, op, a, wd, rd);
      check({tag, "_req"}, 32'({b.mem_en, b.mem_wr, b.mem_wstrb, b.in_ready}),
            32'({1'b1, 1'b1, strb, 1'b0}));
      check({tag, "_wdata"}, b.mem_wdata, lane);
      check({tag, "_addr"}, b.mem_addr, waddr);
      @(negedge clk);
      take(tag, 32'h0, rd, 1'b1, 1'b0);
   endtask

   task automatic load(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] rdata,
                       input logic [31:0] exp, input logic [4:0] rd,
                       input logic [31:0] waddr);
      send(1'b0, op, a, 32'h0, rd);
      check({tag, "_req"}, 32'({b.mem_en, b.mem_wr, b.mem_wstrb}),
            32'({1'b1, 1'b0, 4'b0000}));
      check({tag, "_addr"}, b.mem_addr, waddr);
      @(negedge clk);
      check({tag, "_wait"}, 32'({b.mem_en, b.mem_wr, b.out_valid}), 32'h0);
      @(negedge clk);
      b.mem_rdata = rdata;
      @(negedge clk);
      b.mem_rdata = JUNK;
      take(tag, exp, rd, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      b.in_valid = 0; b.in_store = 0; b.in_op = 0; b.in_addr = 0;
      b.in_wdata = 0; b.in_rd = 0; b.out_ready = 0; b.mem_rdata = 0;
      b5.in_valid = 0; b5.in_store = 0; b5.in_op = 0; b5.in_addr = 0;
      b5.in_wdata = 0; b5.in_rd = 0; b5.out_ready = 0; b5.mem_rdata = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctl",
            32'({b.in_ready, b.out_valid, b.mem_en, b.mem_wr, b.mem_wstrb}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}));
      check("rst_rdata", b.out_rdata, 32'h0);
      check("rst_addr", b.mem_addr, 32'h0);
      check("rst_wdata", b.mem_wdata, 32'h0);
      check("rst_tag", 32'({b.out_rd, b.out_store, b.out_misalign}), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst",
            32'({b.in_ready, b.out_valid, b.mem_en, b.mem_wstrb}),
            32'({1'b1, 1'b0, 1'b0, 4'b0000}));

      store("sb", 3'b000, 32'h8000_0013, 32'h0000_00AB, 5'd5,
            4'b1000, 32'hAB00_0000, 32'h8000_0010);
      store("sh", 3'b001, 32'h8000_0022, 32'hABCD_1234, 5'd6,
            4'b1100, 32'h1234_0000, 32'h8000_0020);
      store("sw", 3'b010, 32'h8000_0104, 32'hCAFE_F00D, 5'd7,
            4'b1111, 32'hCAFE_F00D, 32'h8000_0104);

      load("lb", 3'b000, 32'h8000_0002, 32'h1280_3456, 32'hFFFF_FF80,
           5'd1, 32'h8000_0000);
      load("lbu", 3'b100, 32'h8000_0002, 32'h1280_3456, 32'h0000_0080,
           5'd2, 32'h8000_0000);
      load("lb1", 3'b000, 32'h8000_0001, 32'h1280_3456, 32'h0000_0034,
           5'd3, 32'h8000_0000);
      load("lhu", 3'b101, 32'h8000_0000, 32'h8001_1234, 32'h0000_1234,
           5'd4, 32'h8000_0000);
      load("lw", 3'b010, 32'h8000_0004, 32'h8001_1234, 32'h8001_1234,
           5'd8, 32'h8000_0004);
      load("lrsv", 3'b111, 32'h8000_0008, 32'h8001_1234, 32'h8001_1234,
           5'd9, 32'h8000_0008);

      // LH held under back-pressure, next access queued during handshake
      send(1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd9);
      @(negedge clk);
      @(negedge clk);
      b.mem_rdata = 32'h8001_1234;
      @(negedge clk);
      b.mem_rdata = JUNK;
      for (int i = 0; i < 4; i++) begin
         check("lh_hold_data", b.out_rdata, 32'hFFFF_8001);
         check("lh_hold_ctl", 32'({b.out_valid, b.in_ready, b.out_rd}),
               32'({1'b1, 1'b0, 5'd9}));
         @(negedge clk);
      end
      b.in_valid = 1'b1;
      b.in_store = 1'b0;
      b.in_op    = 3'b100;
      b.in_addr  = 32'h8000_0003;
      b.in_rd    = 5'd10;
      b.out_ready = 1'b1;
      @(negedge clk);
      b.out_ready = 1'b0;
      check("no_same_cycle", 32'({b.out_valid, b.in_ready, b.mem_en}),
            32'({1'b0, 1'b1, 1'b0}));
      @(negedge clk);
      b.in_valid = 1'b0;
      check("next_req", 32'({b.mem_en, b.in_ready}), 32'({1'b1, 1'b0}));
      @(negedge clk);
      @(negedge clk);
      b.mem_rdata = 32'h1280_3456;
      @(negedge clk);
      b.mem_rdata = JUNK;
      take("lbu3", 32'h0000_0012, 5'd10, 1'b0, 1'b0);

`ifdef LSU_MISALIGN_CHK_EN
      send(1'b0, 3'b010, 32'h8000_0011, 32'h0, 5'd11);
      check("lwmis_noreq", 32'({b.mem_en, b.mem_wr}), 32'h0);
      take("lwmis", 32'h0, 5'd11, 1'b0, 1'b1);
      send(1'b1, 3'b001, 32'h8000_0021, 32'h0000_5555, 5'd12);
      check("shmis_noreq", 32'({b.mem_en, b.mem_wr, b.mem_wstrb}), 32'h0);
      take("shmis", 32'h0, 5'd12, 1'b1, 1'b1);
`else
      load("lwmis", 3'b010, 32'h8000_0011, 32'h8001_1234, 32'h8001_1234,
           5'd11, 32'h8000_0010);
      load("lhodd", 3'b001, 32'h8000_0001, 32'h8001_1234, 32'h0000_1234,
           5'd12, 32'h8000_0000);
`endif

      // Reset abort during WAIT on the MEM_LAT=5 instance
      @(negedge clk);
      b5.in_valid = 1'b1;
      b5.in_op    = 3'b010;
      b5.in_addr  = 32'h0000_0100;
      b5.in_rd    = 5'd12;
      b5.mem_rdata = 32'h5A5A_1234;
      @(negedge clk);
      b5.in_valid = 1'b0;
      check("l5_req", 32'(b5.mem_en), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("l5_wait", 32'({b5.mem_en, b5.out_valid}), 32'h0);
      #1 rst_n = 1'b0;
      #1;
      check("l5_abort", 32'({b5.in_ready, b5.out_valid, b5.mem_en}),
            32'({1'b1, 1'b0, 1'b0}));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("l5_quiet", 32'({b5.out_valid, b5.mem_en, b5.in_ready}),
               32'({1'b0, 1'b0, 1'b1}));
      end
      @(negedge clk);
      b5.in_valid = 1'b1;
      b5.in_op    = 3'b010;
      b5.in_addr  = 32'h0000_0200;
      b5.in_rd    = 5'd13;
      @(negedge clk);
      b5.in_valid = 1'b0;
      n = 0;
      while (!b5.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("l5_lat", 32'(n), 32'd6);
      check("l5_data", b5.out_rdata, 32'h5A5A_1234);
      check("l5_tag", 32'(b5.out_rd), 32'd13);
      b5.out_ready = 1'b1;
      @(negedge clk);
      b5.out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
